// File: rtl/photodiode_delay_array.sv
// N-channel photodiode transit-time meter: timestamps thermometer-ordered PD edges,
// publishes per-step and total delays, and flags order, glitch and timeout aborts.
//
// state   | meaning
// IDLE    | beam clear, waiting for PD[0] alone to start a run
// MEASURE | counting ticks, latching a timestamp on each new channel
// DONE    | one cycle, results loaded and meas_valid high
// REARM   | waiting for all channels to clear before the next run
module photodiode_delay_array #(
   parameter int N_CH       = 5,
   parameter int CNT_W      = 12,
   parameter int PRESCALE   = 1,
   parameter int TIMEOUT    = 4095,
   parameter int ACT_THRESH = 2000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_CH-1:0]             PD,
   output logic [(N_CH-1)*CNT_W-1:0]   step_delays,
   output logic [CNT_W-1:0]            total_delay,
   output logic                        meas_valid,
   output logic                        button_activate,
   output logic                        seq_err,
   output logic                        timeout_err,
   output logic                        busy
);

   localparam int LVL_W = $clog2(N_CH + 1);
   localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {IDLE, MEASURE, DONE, REARM} state_t;

   state_t                     state;
   logic [N_CH-1:0]            pd_meta;
   logic [N_CH-1:0]            ps;
   logic [PS_W-1:0]            presc;
   logic [CNT_W-1:0]           cnt;
   logic [CNT_W-1:0]           cnt_next;
   logic [LVL_W-1:0]           prev_lvl;
   logic [CNT_W-1:0]           t_reg  [1:N_CH-1];
   logic [CNT_W-1:0]           t_next [1:N_CH-1];
   logic [(N_CH-1)*CNT_W-1:0]  steps_next;
   logic [CNT_W-1:0]           t_prev;
   logic [N_CH-1:0]            thermo_code;
   logic                       thermo;
   logic                       run;
   logic                       tick;
   int                         lvl;
   int                         prev_i;

   always_comb begin
      lvl         = 0;
      run         = 1'b1;
      thermo_code = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (run && ps[i]) lvl = lvl + 1;
         else              run = 1'b0;
      end
      for (int i = 0; i < N_CH; i++) thermo_code[i] = (i < lvl);
   end

   assign thermo   = (ps == thermo_code);
   assign prev_i   = int'(prev_lvl);
   assign tick     = (presc == PS_W'(PRESCALE - 1));
   assign cnt_next = (cnt == CNT_W'(TIMEOUT)) ? cnt : cnt + CNT_W'(tick);
   assign busy     = (state == MEASURE);

   // Timestamps use the post-tick count so a step of n clocks reads n ticks at PRESCALE=1.
   always_comb begin
      steps_next = '0;
      t_prev     = '0;
      for (int k = 1; k < N_CH; k++) begin
         t_next[k] = t_reg[k];
         if (k >= prev_i && k < lvl) t_next[k] = cnt_next;
         steps_next[(k-1)*CNT_W +: CNT_W] = t_next[k] - t_prev;
         t_prev = t_next[k];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pd_meta         <= '0;
         ps              <= '0;
         state           <= IDLE;
         presc           <= '0;
         cnt             <= '0;
         prev_lvl        <= '0;
         for (int k = 1; k < N_CH; k++) t_reg[k] <= '0;
         step_delays     <= '0;
         total_delay     <= '0;
         meas_valid      <= 1'b0;
         button_activate <= 1'b0;
         seq_err         <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         pd_meta <= PD;
         ps      <= pd_meta;
         case (state)
            IDLE: begin
               if (ps != '0) begin
                  if (ps == N_CH'(1)) begin
                     state           <= MEASURE;
                     presc           <= '0;
                     cnt             <= '0;
                     prev_lvl        <= LVL_W'(1);
                     for (int k = 1; k < N_CH; k++) t_reg[k] <= '0;
                     button_activate <= 1'b0;
                     seq_err         <= 1'b0;
                     timeout_err     <= 1'b0;
                  end else begin
                     state <= REARM;
                  end
               end
            end
            MEASURE: begin
               presc    <= tick ? '0 : presc + PS_W'(1);
               cnt      <= cnt_next;
               t_reg    <= t_next;
               prev_lvl <= LVL_W'(lvl);
               if (!thermo || lvl < prev_i) begin
                  seq_err <= 1'b1;
                  state   <= REARM;
               end else if (lvl == N_CH) begin
                  step_delays     <= steps_next;
                  total_delay     <= t_next[N_CH-1];
                  meas_valid      <= 1'b1;
                  button_activate <= (t_next[N_CH-1] <= CNT_W'(ACT_THRESH));
                  state           <= DONE;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  timeout_err <= 1'b1;
                  state       <= REARM;
               end
            end
            DONE: begin
               meas_valid <= 1'b0;
               state      <= REARM;
            end
            REARM: begin
               if (ps == '0) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
